// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch (port 0)
// and the load/store unit (port 1); one transaction at a time, IDLE -> ACCESS -> WAIT.
module ram_arbiter #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_isReading,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

   state_t            state_q;
   logic              last_grant_q;
   logic              id_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic [DATA_W-1:0] rsp0_rdata_q;
   logic [DATA_W-1:0] rsp1_rdata_q;

   logic              grant_valid;
   logic              grant_id;
   logic              hs;

   always_comb begin
      grant_valid = req0_valid | req1_valid;
      // On a tie the port that did not win last time gets the RAM.
      grant_id    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
      hs          = (state_q == S_IDLE) & grant_valid;
      req0_ready  = ~reset & hs & ~grant_id;
      req1_ready  = ~reset & hs &  grant_id;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (hs) begin
                  id_q         <= grant_id;
                  write_q      <= grant_id ? req1_write : req0_write;
                  addr_q       <= grant_id ? req1_addr  : req0_addr;
                  wdata_q      <= grant_id ? req1_wdata : req0_wdata;
                  last_grant_q <= grant_id;
                  state_q      <= S_ACCESS;
               end
            end
            S_ACCESS: state_q <= S_WAIT;
            S_WAIT: begin
               if (id_q) begin
                  rsp1_valid_q <= 1'b1;
                  rsp1_rdata_q <= write_q ? '0 : ram_dataOut;
               end else begin
                  rsp0_valid_q <= 1'b1;
                  rsp0_rdata_q <= write_q ? '0 : ram_dataOut;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Write enable decoded from state so an async reset kills it before the next edge.
   assign ram_isReading = ~((state_q == S_ACCESS) & write_q);
   assign ram_address   = addr_q;
   assign ram_dataIn    = wdata_q;
   assign rsp0_valid    = rsp0_valid_q;
   assign rsp1_valid    = rsp1_valid_q;
   assign rsp0_rdata    = rsp0_rdata_q;
   assign rsp1_rdata    = rsp1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: per-port request drivers, a behavioural RAM and a
// transaction-level reference (round-robin choice, serial memory image, 3-cycle latency).
module tb_ram_arbiter;

   typedef struct {
      logic        wr;
      logic [10:0] addr;
      logic [63:0] data;
      int unsigned gap;
   } req_t;

   typedef struct {
      logic [63:0] exp;
      int unsigned due;
      logic        wr;
      logic [10:0] addr;
      logic [63:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v [2];
   logic        w [2];
   logic [10:0] a [2];
   logic [63:0] d [2];
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [63:0] rsp0_rdata, rsp1_rdata;
   logic [10:0] ram_address;
   logic        ram_isReading;
   logic [63:0] ram_dataIn;
   logic [63:0] ram_dataOut = '0;

   req_t        dq [2][$];
   exp_t        sb [2][$];
   logic [63:0] ref_mem [int];
   logic [63:0] mem [2048];
   bit          written [2048];

   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   logic        last_g = 1'b1;
   logic        acc_pend = 1'b0;
   logic        acc_wr;
   logic [10:0] acc_addr;
   logic [63:0] acc_data;
   int unsigned acc_cyc;

   ram_arbiter #(.ADDR_W(11), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(v[0]), .req0_write(w[0]), .req0_addr(a[0]), .req0_wdata(d[0]),
      .req0_ready(req0_ready),
      .req1_valid(v[1]), .req1_write(w[1]), .req1_addr(a[1]), .req1_wdata(d[1]),
      .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_address(ram_address), .ram_isReading(ram_isReading),
      .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] init_word(input logic [10:0] ad);
      return 64'hC0DE_5A5A_0000_0000 ^ {53'b0, ad};
   endfunction

   // Behavioural synchronous single-port RAM.
   always @(posedge clk) begin
      if (!ram_isReading) begin
         mem[ram_address]     <= ram_dataIn;
         written[ram_address] <= 1'b1;
      end
      ram_dataOut <= written[ram_address] ? mem[ram_address] : init_word(ram_address);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_read(input logic [10:0] ad);
      return ref_mem.exists(int'(ad)) ? ref_mem[int'(ad)] : init_word(ad);
   endfunction

   task automatic chk_rsp(input int p, input logic vld, input logic [63:0] data);
      exp_t e;
      if (vld) begin
         if (sb[p].size() == 0) begin
            check($sformatf("rsp%0d_unexpected", p), 64'(vld), 64'h0);
         end else begin
            e = sb[p].pop_front();
            check($sformatf("rsp%0d_rdata", p), data, e.exp);
            check($sformatf("rsp%0d_latency", p), 64'(cyc), 64'(e.due));
            if (e.wr) ref_mem[int'(e.addr)] = e.wdata;
         end
      end
      if (sb[p].size() > 0 && sb[p][0].due < cyc) begin
         check($sformatf("rsp%0d_missing", p), 64'(vld), 64'h1);
         void'(sb[p].pop_front());
      end
   endtask

   // Monitor / reference model.
   always @(negedge clk) begin
      logic idle, e0, e1, g;
      exp_t e;
      if (reset) begin
         sb[0].delete();
         sb[1].delete();
         last_g   = 1'b1;
         acc_pend = 1'b0;
         check("reset_ready", {62'b0, req1_ready, req0_ready}, 64'h0);
         check("reset_rspvalid", {62'b0, rsp1_valid, rsp0_valid}, 64'h0);
         check("reset_isreading", 64'(ram_isReading), 64'h1);
         check("reset_address", 64'(ram_address), 64'h0);
         check("reset_datain", ram_dataIn, 64'h0);
         check("reset_rdata", rsp0_rdata | rsp1_rdata, 64'h0);
      end else begin
         chk_rsp(0, rsp0_valid, rsp0_rdata);
         chk_rsp(1, rsp1_valid, rsp1_rdata);
         if (acc_pend && cyc == acc_cyc + 1) begin
            check("access_isreading", 64'(ram_isReading), 64'(!acc_wr));
            check("access_address", 64'(ram_address), 64'(acc_addr));
            if (acc_wr) check("access_datain", ram_dataIn, acc_data);
            acc_pend = 1'b0;
         end else begin
            check("idle_isreading", 64'(ram_isReading), 64'h1);
         end
         idle = (sb[0].size() == 0) && (sb[1].size() == 0) && !acc_pend;
         e0 = 1'b0;
         e1 = 1'b0;
         g  = 1'b0;
         if (idle && (v[0] || v[1])) begin
            g = (v[0] && v[1]) ? (last_g == 1'b1 ? 1'b0 : 1'b1) : v[1];
            if (g) e1 = 1'b1; else e0 = 1'b1;
         end
         check("ready0", 64'(req0_ready), 64'(e0));
         check("ready1", 64'(req1_ready), 64'(e1));
         if (e0 || e1) begin
            e.wr    = w[g];
            e.addr  = a[g];
            e.wdata = d[g];
            e.exp   = w[g] ? 64'h0 : ref_read(a[g]);
            e.due   = cyc + 3;
            sb[g].push_back(e);
            last_g   = g;
            acc_pend = 1'b1;
            acc_cyc  = cyc;
            acc_wr   = w[g];
            acc_addr = a[g];
            acc_data = d[g];
         end
      end
   end

   // Requester drivers: hold a request until accepted, then load the next after its gap.
   initial begin
      logic hs [2];
      req_t r;
      for (int p = 0; p < 2; p++) begin
         v[p] = 1'b0; w[p] = 1'b0; a[p] = '0; d[p] = '0;
      end
      forever begin
         @(negedge clk);
         hs[0] = v[0] && req0_ready;
         hs[1] = v[1] && req1_ready;
         @(posedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (hs[p]) v[p] = 1'b0;
            if (!v[p] && dq[p].size() > 0) begin
               if (dq[p][0].gap > 0) begin
                  dq[p][0].gap = dq[p][0].gap - 1;
               end else begin
                  r = dq[p].pop_front();
                  v[p] = 1'b1; w[p] = r.wr; a[p] = r.addr; d[p] = r.data;
               end
            end
         end
      end
   end

   task automatic push(input int p, input logic wr, input logic [10:0] ad,
                       input logic [63:0] dt, input int unsigned gap);
      req_t r;
      r.wr = wr; r.addr = ad; r.data = dt; r.gap = gap;
      dq[p].push_back(r);
   endtask

   task automatic wait_done(input int unsigned budget);
      bit done = 1'b0;
      for (int unsigned i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #2;
         done = dq[0].size() == 0 && dq[1].size() == 0 && !v[0] && !v[1] &&
                sb[0].size() == 0 && sb[1].size() == 0 && !acc_pend;
      end
      if (!done) check("drain_timeout", 64'h0, 64'h1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      push(1, 1'b1, 11'd1024, 64'hff04, 0);
      wait_done(50);
      push(0, 1'b0, 11'd1024, 64'h0, 0);
      push(0, 1'b0, 11'd1023, 64'h0, 0);
      wait_done(50);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b0, 11'd10, 64'h0, 0);
         push(1, 1'b0, 11'd20, 64'h0, 0);
      end
      wait_done(100);

      push(0, 1'b1, 11'd5, 64'h1, 0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         #1 seen = acc_pend;
      end
      check("abort_accepted", 64'(seen), 64'h1);
      @(posedge clk);
      #2;
      check("abort_in_access", 64'(ram_isReading), 64'h0);
      reset = 1'b1;
      #1 check("abort_isreading", 64'(ram_isReading), 64'h1);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      push(0, 1'b0, 11'd5, 64'h0, 0);
      wait_done(50);

      push(0, 1'b0, 11'd1024, 64'h0, 0);
      push(0, 1'b0, 11'd10, 64'h0, 0);
      push(0, 1'b1, 11'd10, 64'hABCD, 0);
      wait_done(50);
      repeat (10) @(posedge clk);

      for (int i = 0; i < 80; i++) begin
         logic [10:0] ad;
         ad = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7))
                                          : 11'($urandom_range(2040, 2047));
         push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad,
              {$urandom, $urandom}, $urandom_range(0, 3));
      end
      wait_done(3000);

      check("final_sb_empty", 64'(sb[0].size() + sb[1].size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
